ctrl_fetch_stage: RTL and testbench
===================================

CTRL_FETCH_STAGE -- requirements
Module: ctrl_fetch_stage

Interface
REQ-001 The block SHALL have parameter PROG_CTR_WID, default 10, program-counter width.
REQ-002 The block SHALL have parameter INSTR_WID, default 16, instruction word width.
REQ-003 The block SHALL have parameter CNT_WID, default 16, performance-counter width.
REQ-004 The block SHALL use a single clock and a synchronous, active-high reset, with ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- prog_ctr  input  PROG_CTR_WID  current fetch address from the program counter.
- branch_taken_EX  input  1  taken branch resolved in EX; the program counter loads the target on the same edge.
- imem_rdata  input  INSTR_WID  instruction memory read data; synchronous read, valid one cycle after the address.
- imem_addr  output  PROG_CTR_WID  instruction memory address; combinational copy of prog_ctr.
- imem_en  output  1  memory read enable; equals ~reset.
- instr_ID  output  INSTR_WID  instruction handed to decode.
- pc_ID  output  PROG_CTR_WID  address of instr_ID.
- valid_ID  output  1  instr_ID is a real, non-squashed instruction.
- fe_state  output  2  FSM state: 0 FILL, 1 RUN, 2 FLUSH.
- fetch_cnt  output  CNT_WID  count of cycles with valid_ID=1.
- flush_cnt  output  CNT_WID  count of cycles with branch_taken_EX=1 (reset excluded).

Function
REQ-005 Pipeline shape: address issue (cycle t), F1 (t+1, memory data returns), ID register (visible from t+2).
REQ-006 F1 SHALL register pc_F1<=prog_ctr and valid_F1<=1 each cycle, except valid_F1<=0 when reset or branch_taken_EX is 1.
REQ-007 The ID register SHALL update every edge: instr_ID<=imem_rdata, pc_ID<=pc_F1, valid_ID<=valid_F1 & ~branch_taken_EX & ~reset.
REQ-008 Latency SHALL be 2 cycles: the address presented in cycle t appears on instr_ID/pc_ID in cycle t+2.
REQ-009 A branch asserted in cycle b SHALL squash exactly the two younger in-flight fetches: valid_ID=0 in cycles b+1 and b+2, and the target becomes valid in cycle b+3.
REQ-010 The block SHALL not stall; there is no hold input, and one instruction advances per cycle.
REQ-011 The FSM SHALL have state FILL, entered on reset, which moves to RUN after one non-reset cycle, or to FLUSH if branch_taken_EX is 1 in that cycle.
REQ-012 From RUN, the FSM SHALL move to FLUSH when branch_taken_EX is 1, and otherwise stay in RUN.
REQ-013 FLUSH SHALL last 2 cycles via an internal down-counter; a branch during FLUSH reloads the counter to 2, and expiry returns the FSM to RUN.
REQ-014 valid_ID SHALL be 0 whenever fe_state is FILL or FLUSH, consistent with REQ-007.
REQ-015 Back-to-back branches SHALL each squash independently; valid_ID resumes 3 cycles after the last branch.
REQ-016 fetch_cnt SHALL increment when valid_ID=1 and saturate at all-ones without wrapping.
REQ-017 flush_cnt SHALL increment on each non-reset cycle with branch_taken_EX=1 and saturate at all-ones.
REQ-018 pc_F1 and pc_ID SHALL be PROG_CTR_WID wide, and PC wrap-around from all-ones to 0 SHALL pass through unchanged.

Reset
REQ-019 While reset=1, the block SHALL set valid_F1=0, valid_ID=0, instr_ID=0, pc_ID=0, pc_F1=0, fetch_cnt=0, flush_cnt=0, fe_state=FILL, and the flush counter to 0.
REQ-020 A reset asserted mid-FLUSH or mid-stream SHALL take effect on the next edge with no residual valid instruction.
REQ-021 After the cycle with reset=1, the first valid_ID SHALL appear 2 cycles after reset deasserts, with pc_ID=0.

Verification
REQ-022 Reset release with mem[k]=16'h1000+k: valid_ID rises in the 2nd cycle after release with pc_ID=0, instr_ID=16'h1000; pc_ID then increments by 1 every cycle.
REQ-023 Branch in cycle b, target 10'h080: valid_ID=0 in cycles b+1 and b+2, pc_ID=10'h080 and valid_ID=1 in cycle b+3, flush_cnt increments by 1, and fe_state=FLUSH for 2 cycles.
REQ-024 Branches in cycles b and b+1: valid_ID=0 in cycles b+1 through b+3, the second target is valid in cycle b+4, and flush_cnt increments by 2.
REQ-025 Reset asserted during FLUSH: on the next edge valid_ID=0, both counters are 0, fe_state=FILL, and normal fill resumes per REQ-021.
REQ-026 PC wrap, prog_ctr 10'h3FF then 10'h000: pc_ID shows 3FF then 000 with no bubble.
REQ-027 With CNT_WID=4 and 20 valid cycles: fetch_cnt holds at 4'hF.

Source files
------------

// File: rtl/ctrl_fetch_stage.sv
// Two-stage instruction fetch front end: F1 register plus ID register, with
// branch squash, a fill/run/flush FSM and saturating performance counters.
module ctrl_fetch_stage #(
    parameter int PROG_CTR_WID = 10,
    parameter int INSTR_WID    = 16,
    parameter int CNT_WID      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PROG_CTR_WID-1:0] prog_ctr,
    input  logic                    branch_taken_EX,
    input  logic [INSTR_WID-1:0]    imem_rdata,
    output logic [PROG_CTR_WID-1:0] imem_addr,
    output logic                    imem_en,
    output logic [INSTR_WID-1:0]    instr_ID,
    output logic [PROG_CTR_WID-1:0] pc_ID,
    output logic                    valid_ID,
    output logic [1:0]              fe_state,
    output logic [CNT_WID-1:0]      fetch_cnt,
    output logic [CNT_WID-1:0]      flush_cnt
);

    // state | meaning
    // FILL  | first cycle after reset, pipeline empty
    // RUN   | streaming, one instruction per cycle
    // FLUSH | two cycles of squashed fetches after a taken branch
    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic [1:0]              flush_ctr;
    logic [1:0]              flush_ctr_nxt;
    logic [PROG_CTR_WID-1:0] pc_F1;
    logic                    valid_F1;

    assign imem_addr = prog_ctr;
    assign imem_en   = ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_FILL;
            flush_ctr <= 2'd0;
        end else begin
            state     <= state_nxt;
            flush_ctr <= flush_ctr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        flush_ctr_nxt = flush_ctr;
        case (state)
            ST_FILL, ST_RUN: begin
                if (branch_taken_EX) begin
                    state_nxt     = ST_FLUSH;
                    flush_ctr_nxt = 2'd2;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (branch_taken_EX) begin
                    flush_ctr_nxt = 2'd2;
                end else if (flush_ctr <= 2'd1) begin
                    state_nxt     = ST_RUN;
                    flush_ctr_nxt = 2'd0;
                end else begin
                    flush_ctr_nxt = flush_ctr - 2'd1;
                end
            end
            default: begin
                state_nxt     = ST_FILL;
                flush_ctr_nxt = 2'd0;
            end
        endcase
    end

    always_comb begin
        fe_state = state;
    end

    // Validity alone carries the squash; pc/instr flow through unconditionally.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_F1    <= '0;
            valid_F1 <= 1'b0;
            pc_ID    <= '0;
            instr_ID <= '0;
            valid_ID <= 1'b0;
        end else begin
            pc_F1    <= prog_ctr;
            valid_F1 <= ~branch_taken_EX;
            pc_ID    <= pc_F1;
            instr_ID <= imem_rdata;
            valid_ID <= valid_F1 & ~branch_taken_EX;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (valid_ID && (fetch_cnt != {CNT_WID{1'b1}}))
                fetch_cnt <= fetch_cnt + CNT_WID'(1);
            if (branch_taken_EX && (flush_cnt != {CNT_WID{1'b1}}))
                flush_cnt <= flush_cnt + CNT_WID'(1);
        end
    end

endmodule

// File: tb/tb_ctrl_fetch_stage.sv
// Directed bench for ctrl_fetch_stage: a stimulus/expectation table plus
// hand sequences for counter saturation and back-to-back branch flushes.
module tb_ctrl_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  prog_ctr;
    logic        branch_taken_EX;
    logic [15:0] imem_rdata;

    logic [9:0]  imem_addr, pc_ID;
    logic        imem_en, valid_ID;
    logic [15:0] instr_ID, fetch_cnt, flush_cnt;
    logic [1:0]  fe_state;

    logic [9:0]  s_imem_addr, s_pc_ID;
    logic        s_imem_en, s_valid_ID;
    logic [15:0] s_instr_ID;
    logic [1:0]  s_fe_state;
    logic [3:0]  s_fetch_cnt, s_flush_cnt;

    logic [9:0]  pc_cur = 10'h000;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    ctrl_fetch_stage u_dut (
        .clk(clk), .reset(reset), .prog_ctr(prog_ctr),
        .branch_taken_EX(branch_taken_EX), .imem_rdata(imem_rdata),
        .imem_addr(imem_addr), .imem_en(imem_en), .instr_ID(instr_ID),
        .pc_ID(pc_ID), .valid_ID(valid_ID), .fe_state(fe_state),
        .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
    );

    ctrl_fetch_stage #(.CNT_WID(4)) u_sat (
        .clk(clk), .reset(reset), .prog_ctr(prog_ctr),
        .branch_taken_EX(branch_taken_EX), .imem_rdata(imem_rdata),
        .imem_addr(s_imem_addr), .imem_en(s_imem_en), .instr_ID(s_instr_ID),
        .pc_ID(s_pc_ID), .valid_ID(s_valid_ID), .fe_state(s_fe_state),
        .fetch_cnt(s_fetch_cnt), .flush_cnt(s_flush_cnt)
    );

    // Synchronous-read memory with mem[k] = 16'h1000 + k.
    always @(posedge clk) imem_rdata <= 16'h1000 | {6'b0, imem_addr};

    typedef struct {
        logic        rst;
        logic        br;
        logic [9:0]  tgt;
        logic        chk;
        logic        e_valid;
        logic [9:0]  e_pc;
        logic [15:0] e_instr;
        logic [1:0]  e_state;
        logic [15:0] e_fetch;
        logic [15:0] e_flush;
    } vec_t;

    vec_t vecs[26];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic step(input logic rst, input logic br, input logic [9:0] tgt);
        reset           = rst;
        branch_taken_EX = br;
        prog_ctr        = pc_cur;
        #1;
        check("imem_addr", {22'b0, imem_addr}, {22'b0, pc_cur});
        check("imem_en", {31'b0, imem_en}, {31'b0, ~rst});
        @(posedge clk);
        if (rst)     pc_cur = 10'h000;
        else if (br) pc_cur = tgt;
        else         pc_cur = pc_cur + 10'd1;
        @(negedge clk);
    endtask

    initial begin
        //            rst  br   tgt     chk  v    pc      instr     st    fetch flush
        vecs[0]  = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 16'h0000, 2'd0, 16'd0, 16'd0};
        vecs[1]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 16'h0000, 2'd1, 16'd0, 16'd0};
        vecs[2]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h000, 16'h1000, 2'd1, 16'd0, 16'd0};
        vecs[3]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h001, 16'h1001, 2'd1, 16'd1, 16'd0};
        vecs[4]  = '{1'b0, 1'b1, 10'h080, 1'b0, 1'b0, 10'h000, 16'h0000, 2'd2, 16'd2, 16'd1};
        vecs[5]  = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 16'h0000, 2'd2, 16'd2, 16'd1};
        vecs[6]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h080, 16'h1080, 2'd1, 16'd2, 16'd1};
        vecs[7]  = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h081, 16'h1081, 2'd1, 16'd3, 16'd1};
        vecs[8]  = '{1'b0, 1'b1, 10'h3FE, 1'b0, 1'b0, 10'h000, 16'h0000, 2'd2, 16'd4, 16'd2};
        vecs[9]  = '{1'b0, 1'b1, 10'h200, 1'b0, 1'b0, 10'h000, 16'h0000, 2'd2, 16'd4, 16'd3};
        vecs[10] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 16'h0000, 2'd2, 16'd4, 16'd3};
        vecs[11] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h200, 16'h1200, 2'd1, 16'd4, 16'd3};
        vecs[12] = '{1'b0, 1'b1, 10'h3FE, 1'b0, 1'b0, 10'h000, 16'h0000, 2'd2, 16'd5, 16'd4};
        vecs[13] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 16'h0000, 2'd2, 16'd5, 16'd4};
        vecs[14] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h3FE, 16'h13FE, 2'd1, 16'd5, 16'd4};
        vecs[15] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h3FF, 16'h13FF, 2'd1, 16'd6, 16'd4};
        vecs[16] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h000, 16'h1000, 2'd1, 16'd7, 16'd4};
        vecs[17] = '{1'b0, 1'b1, 10'h100, 1'b0, 1'b0, 10'h000, 16'h0000, 2'd2, 16'd8, 16'd5};
        vecs[18] = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 16'h0000, 2'd0, 16'd0, 16'd0};
        vecs[19] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 16'h0000, 2'd1, 16'd0, 16'd0};
        vecs[20] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h000, 16'h1000, 2'd1, 16'd0, 16'd0};
        vecs[21] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h001, 16'h1001, 2'd1, 16'd1, 16'd0};
        vecs[22] = '{1'b1, 1'b1, 10'h055, 1'b1, 1'b0, 10'h000, 16'h0000, 2'd0, 16'd0, 16'd0};
        vecs[23] = '{1'b0, 1'b1, 10'h040, 1'b0, 1'b0, 10'h000, 16'h0000, 2'd2, 16'd0, 16'd1};
        vecs[24] = '{1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 16'h0000, 2'd2, 16'd0, 16'd1};
        vecs[25] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h040, 16'h1040, 2'd1, 16'd0, 16'd1};

        reset           = 1'b1;
        branch_taken_EX = 1'b0;
        prog_ctr        = 10'h000;
        @(negedge clk);

        for (int i = 0; i < 26; i++) begin
            step(vecs[i].rst, vecs[i].br, vecs[i].tgt);
            check($sformatf("v%0d valid_ID", i), {31'b0, valid_ID}, {31'b0, vecs[i].e_valid});
            check($sformatf("v%0d fe_state", i), {30'b0, fe_state}, {30'b0, vecs[i].e_state});
            check($sformatf("v%0d fetch_cnt", i), {16'b0, fetch_cnt}, {16'b0, vecs[i].e_fetch});
            check($sformatf("v%0d flush_cnt", i), {16'b0, flush_cnt}, {16'b0, vecs[i].e_flush});
            check($sformatf("v%0d sat valid_ID", i), {31'b0, s_valid_ID}, {31'b0, vecs[i].e_valid});
            check($sformatf("v%0d sat fe_state", i), {30'b0, s_fe_state}, {30'b0, vecs[i].e_state});
            if (vecs[i].chk) begin
                check($sformatf("v%0d pc_ID", i), {22'b0, pc_ID}, {22'b0, vecs[i].e_pc});
                check($sformatf("v%0d instr_ID", i), {16'b0, instr_ID}, {16'b0, vecs[i].e_instr});
                check($sformatf("v%0d sat pc_ID", i), {22'b0, s_pc_ID}, {22'b0, vecs[i].e_pc});
                check($sformatf("v%0d sat instr_ID", i), {16'b0, s_instr_ID}, {16'b0, vecs[i].e_instr});
            end
        end

        // 20 valid cycles: the 4-bit counter must hold at F instead of wrapping.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 10'h000);
        check("fetch_cnt after 20", {16'b0, fetch_cnt}, 32'd20);
        check("sat fetch_cnt", {28'b0, s_fetch_cnt}, 32'hF);
        check("sat valid_ID streaming", {31'b0, s_valid_ID}, 32'd1);

        // 17 back-to-back branches: flush counters, saturation, resume after the last one.
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 10'h000);
        check("flush_cnt after 17", {16'b0, flush_cnt}, 32'd18);
        check("sat flush_cnt", {28'b0, s_flush_cnt}, 32'hF);
        check("burst valid_ID b+1", {31'b0, valid_ID}, 32'd0);
        check("burst fe_state b+1", {30'b0, fe_state}, 32'd2);
        step(1'b0, 1'b0, 10'h000);
        check("burst valid_ID b+2", {31'b0, valid_ID}, 32'd0);
        check("burst fe_state b+2", {30'b0, fe_state}, 32'd2);
        step(1'b0, 1'b0, 10'h000);
        check("burst valid_ID b+3", {31'b0, valid_ID}, 32'd1);
        check("burst pc_ID b+3", {22'b0, pc_ID}, 32'h000);
        check("burst instr_ID b+3", {16'b0, instr_ID}, 32'h1000);
        check("burst fe_state b+3", {30'b0, fe_state}, 32'd1);
        check("burst flush_cnt hold", {16'b0, flush_cnt}, 32'd18);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
